cypher_streamer: RTL and testbench

Transmit-side companion to the `bonus` nibble comparator. It accepts a 16-bit cypher word on a one-cycle `start` request and serialises it MSB-nibble-first onto a 4-bit `compared` bus, qualifying each nibble with a one-cycle `read` strobe. It keeps a running 8-bit sum of the emitted nibbles and pulses `done` after the last one. Its outputs drive `bonus.compared`/`bonus.read` directly in the integration bench and top level.

---
 rtl/cypher_streamer.sv | 136 +++++++++++++
 tb/tb_cypher_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cypher_streamer.sv
// cypher_streamer: serialises a 16-bit cypher word MSB-nibble-first onto a
// 4-bit bus with a one-cycle read strobe per nibble, a configurable idle gap
// between strobes, a running nibble sum and a done pulse after the last nibble.
// Optional feature macro: CYPHER_STREAMER_CHECKSUM_EN appends a fifth nibble
// that makes the low nibble of the final sum zero.
module cypher_streamer #(
   parameter int GAP = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] cypher,
   output logic [3:0]  compared,
   output logic        read,
   output logic        busy,
   output logic        done,
   output logic [7:0]  sum
);

`ifdef CYPHER_STREAMER_CHECKSUM_EN
   localparam int N = 5;
`else
   localparam int N = 4;
`endif

   localparam logic [2:0] LAST     = 3'(N - 1);
   // Only meaningful when GAP > 0; the WAIT state is unreachable otherwise.
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t      state, state_n;
   logic [15:0] shreg, shreg_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  cnt, cnt_n;
   logic [3:0]  compared_n;
   logic [7:0]  sum_n;
   logic        read_n, busy_n, done_n;
   logic        emit;
   logic [3:0]  nib_next;

   // Next nibble to put on the bus once the current strobe/gap is finished.
   always_comb begin
`ifdef CYPHER_STREAMER_CHECKSUM_EN
      nib_next = (idx == 3'd3) ? (4'd0 - sum[3:0]) : shreg[15:12];
`else
      nib_next = shreg[15:12];
`endif
   end

   // Next-state and registered-output decode; outputs are registered so the
   // strobe, the nibble and the sum that includes it all appear together.
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      idx_n      = idx;
      cnt_n      = cnt;
      compared_n = compared;
      sum_n      = sum;
      read_n     = 1'b0;
      busy_n     = busy;
      done_n     = 1'b0;
      emit       = 1'b0;
      case (state)
         IDLE, DONE: begin
            busy_n  = 1'b0;
            state_n = IDLE;
            if (start) begin
               state_n    = SEND;
               shreg_n    = {cypher[11:0], 4'h0};
               idx_n      = 3'd0;
               cnt_n      = 8'd0;
               compared_n = cypher[15:12];
               sum_n      = {4'h0, cypher[15:12]};
               read_n     = 1'b1;
               busy_n     = 1'b1;
            end
         end
         SEND: begin
            if (idx == LAST) begin
               state_n = DONE;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else if (GAP == 0) begin
               emit = 1'b1;
            end else begin
               state_n = WAIT;
               cnt_n   = 8'd0;
            end
         end
         WAIT: begin
            if (cnt == GAP_LAST) emit = 1'b1;
            else cnt_n = cnt + 8'd1;
         end
         default: state_n = IDLE;
      endcase
      if (emit) begin
         state_n    = SEND;
         idx_n      = idx + 3'd1;
         shreg_n    = {shreg[11:0], 4'h0};
         compared_n = nib_next;
         sum_n      = sum + {4'h0, nib_next};
         read_n     = 1'b1;
         busy_n     = 1'b1;
      end
   end

   // Control state and visible outputs; reset discards any in-flight word.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= 3'd0;
         cnt      <= 8'd0;
         compared <= 4'h0;
         read     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= 8'h0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         cnt      <= cnt_n;
         compared <= compared_n;
         read     <= read_n;
         busy     <= busy_n;
         done     <= done_n;
         sum      <= sum_n;
      end
   end

   // Word shift register; pure data, only ever read after a fresh load.
   always_ff @(posedge clock) begin
      shreg <= shreg_n;
   end

endmodule

// File: tb/tb_cypher_streamer.sv
// Directed bench for cypher_streamer: one instance with GAP=2, one with GAP=0.
module tb_cypher_streamer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start2 = 1'b0;
   logic        start0 = 1'b0;
   logic [15:0] cypher = 16'h0000;

   logic [3:0]  cmp2, cmp0;
   logic        rd2, rd0, bsy2, bsy0, dn2, dn0;
   logic [7:0]  sum2, sum0;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef CYPHER_STREAMER_CHECKSUM_EN
   localparam int N = 5;
   localparam int DONE2 = 14;
   localparam int DONE0 = 6;
`else
   localparam int N = 4;
   localparam int DONE2 = 11;
   localparam int DONE0 = 5;
`endif

   // Hand-computed strobe cycles (relative to acceptance edge), nibbles and
   // running sums: row 0 = GAP 2 / 0x65A9, row 1 = GAP 0 / 0xFFFF.
   int         strobe_t [2][5] = '{'{1, 4, 7, 10, 13}, '{1, 2, 3, 4, 5}};
   logic [3:0] nib_t    [2][5] = '{'{4'h6, 4'h5, 4'hA, 4'h9, 4'h2},
                                   '{4'hF, 4'hF, 4'hF, 4'hF, 4'h4}};
   logic [7:0] sum_t    [2][5] = '{'{8'd6, 8'd11, 8'd21, 8'd30, 8'd32},
                                   '{8'd15, 8'd30, 8'd45, 8'd60, 8'd64}};
   int         done_t   [2]    = '{DONE2, DONE0};

   always #5 clock = ~clock;

   cypher_streamer #(.GAP(2)) u_g2 (
      .clock(clock), .reset(reset), .start(start2), .cypher(cypher),
      .compared(cmp2), .read(rd2), .busy(bsy2), .done(dn2), .sum(sum2)
   );

   cypher_streamer #(.GAP(0)) u_g0 (
      .clock(clock), .reset(reset), .start(start0), .cypher(cypher),
      .compared(cmp0), .read(rd0), .busy(bsy0), .done(dn0), .sum(sum0)
   );

   // Expected outputs in cycle p after acceptance, looked up from the tables.
   function automatic void model(input int sel, input int p,
                                 output logic er, output logic [3:0] ec,
                                 output logic [7:0] es, output logic ed,
                                 output logic eb);
      er = 1'b0;
      ec = 4'h0;
      es = 8'h0;
      ed = (p == done_t[sel]);
      eb = (p >= 1 && p < done_t[sel]);
      for (int k = 0; k < N; k++) begin
         if (strobe_t[sel][k] == p) er = 1'b1;
         if (strobe_t[sel][k] <= p) begin
            ec = nib_t[sel][k];
            es = sum_t[sel][k];
         end
      end
   endfunction

   task automatic test_reset();
      reset  = 1'b1;
      start2 = 1'b1;
      start0 = 1'b1;
      cypher = 16'hFFFF;
      repeat (3) @(negedge clock);
      n_tests++;
      if ({cmp2, rd2, bsy2, dn2, sum2} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_g2 got %h exp 0", {cmp2, rd2, bsy2, dn2, sum2});
      end
      n_tests++;
      if ({cmp0, rd0, bsy0, dn0, sum0} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_g0 got %h exp 0", {cmp0, rd0, bsy0, dn0, sum0});
      end
      start2 = 1'b0;
      start0 = 1'b0;
      reset  = 1'b0;
      repeat (2) @(negedge clock);
      n_tests++;
      if ({rd2, bsy2, rd0, bsy0} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_release got %b exp 0000", {rd2, bsy2, rd0, bsy0});
      end
   endtask

   // GAP=2 single word; optional start pulse with 0x1234 while busy.
   task automatic test_gap2(input string name, input bit inject);
      logic er, ed, eb;
      logic [3:0] ec;
      logic [7:0] es;
      @(negedge clock);
      cypher = 16'h65A9;
      start2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
      cypher = 16'h0000;
      for (int p = 1; p <= DONE2 + 3; p++) begin
         model(0, p, er, ec, es, ed, eb);
         n_tests++;
         if (rd2 !== er) begin
            n_fail++; $display("FAIL %s read p=%0d got %b exp %b", name, p, rd2, er);
         end
         n_tests++;
         if (cmp2 !== ec) begin
            n_fail++; $display("FAIL %s compared p=%0d got %h exp %h", name, p, cmp2, ec);
         end
         n_tests++;
         if (sum2 !== es) begin
            n_fail++; $display("FAIL %s sum p=%0d got %0d exp %0d", name, p, sum2, es);
         end
         n_tests++;
         if (dn2 !== ed) begin
            n_fail++; $display("FAIL %s done p=%0d got %b exp %b", name, p, dn2, ed);
         end
         n_tests++;
         if (bsy2 !== eb) begin
            n_fail++; $display("FAIL %s busy p=%0d got %b exp %b", name, p, bsy2, eb);
         end
         if (inject && p == 3) begin
            start2 = 1'b1;
            cypher = 16'h1234;
         end else begin
            start2 = 1'b0;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_gap0();
      logic er, ed, eb;
      logic [3:0] ec;
      logic [7:0] es;
      @(negedge clock);
      cypher = 16'hFFFF;
      start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      for (int p = 1; p <= DONE0 + 3; p++) begin
         model(1, p, er, ec, es, ed, eb);
         n_tests++;
         if (rd0 !== er) begin
            n_fail++; $display("FAIL gap0 read p=%0d got %b exp %b", p, rd0, er);
         end
         n_tests++;
         if (cmp0 !== ec) begin
            n_fail++; $display("FAIL gap0 compared p=%0d got %h exp %h", p, cmp0, ec);
         end
         n_tests++;
         if (sum0 !== es) begin
            n_fail++; $display("FAIL gap0 sum p=%0d got %0d exp %0d", p, sum0, es);
         end
         n_tests++;
         if (dn0 !== ed) begin
            n_fail++; $display("FAIL gap0 done p=%0d got %b exp %b", p, dn0, ed);
         end
         n_tests++;
         if (bsy0 !== eb) begin
            n_fail++; $display("FAIL gap0 busy p=%0d got %b exp %b", p, bsy0, eb);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid();
      logic er, ed, eb;
      logic [3:0] ec;
      logic [7:0] es;
      int strobes;
      @(negedge clock);
      cypher = 16'h65A9;
      start2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
      for (int p = 1; p <= 5; p++) begin
         model(0, p, er, ec, es, ed, eb);
         n_tests++;
         if (rd2 !== er || cmp2 !== ec) begin
            n_fail++;
            $display("FAIL rstmid pre p=%0d got %b/%h exp %b/%h", p, rd2, cmp2, er, ec);
         end
         if (p == 5) reset = 1'b1;
         @(negedge clock);
      end
      reset = 1'b0;
      n_tests++;
      if ({cmp2, rd2, bsy2, dn2, sum2} !== 16'h0) begin
         n_fail++;
         $display("FAIL rstmid clear got %h exp 0", {cmp2, rd2, bsy2, dn2, sum2});
      end
      for (int p = 0; p < 8; p++) begin
         @(negedge clock);
         n_tests++;
         if ({rd2, bsy2, dn2} !== 3'b0) begin
            n_fail++;
            $display("FAIL rstmid quiet c=%0d got %b exp 000", p, {rd2, bsy2, dn2});
         end
      end
      cypher = 16'h0000;
      start2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
      strobes = 0;
      for (int p = 1; p <= DONE2 + 1; p++) begin
         model(0, p, er, ec, es, ed, eb);
         if (rd2 === 1'b1) strobes++;
         n_tests++;
         if (rd2 !== er || dn2 !== ed || cmp2 !== 4'h0 || sum2 !== 8'h0) begin
            n_fail++;
            $display("FAIL rstmid zero p=%0d got rd%b dn%b c%h s%0d exp rd%b dn%b c0 s0",
                     p, rd2, dn2, cmp2, sum2, er, ed);
         end
         @(negedge clock);
      end
      n_tests++;
      if (strobes !== N) begin
         n_fail++; $display("FAIL rstmid strobes got %0d exp %0d", strobes, N);
      end
   endtask

   task automatic test_back_to_back();
      logic er, ed, eb;
      logic [3:0] ec;
      logic [7:0] es;
      int p;
      @(negedge clock);
      cypher = 16'h65A9;
      start2 = 1'b1;
      @(negedge clock);
      for (int q = 1; q <= 2 * DONE2 + 2; q++) begin
         p = ((q - 1) % DONE2) + 1;
         model(0, p, er, ec, es, ed, eb);
         n_tests++;
         if (rd2 !== er || cmp2 !== ec || sum2 !== es) begin
            n_fail++;
            $display("FAIL b2b data q=%0d got %b/%h/%0d exp %b/%h/%0d",
                     q, rd2, cmp2, sum2, er, ec, es);
         end
         n_tests++;
         if (dn2 !== ed || bsy2 !== eb) begin
            n_fail++;
            $display("FAIL b2b ctrl q=%0d got %b%b exp %b%b", q, dn2, bsy2, ed, eb);
         end
         @(negedge clock);
      end
      start2 = 1'b0;
      repeat (DONE2 + 2) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_gap2("gap2", 1'b0);
      test_gap0();
      test_gap2("ignore_busy", 1'b1);
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
